mem_port_arbiter: RTL and testbench

- Shares one single-ported synchronous memory between two requesters: the instruction-fetch stage (read-only) and the memory-access stage (read/write).
- Grants one access per cycle and returns read data one cycle later, tagged to its owner.
- Raises a fetch stall when the fetch request loses arbitration.
- Data port has fixed priority, with a starvation guard so fetch always makes progress.

---
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/data requester and memory-port signal bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    // fetch requester
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;
    logic              if_stall;
    // data requester
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    // memory port
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // arbiter side
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_gnt, i_rvalid, i_rdata, if_stall,
               d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    // requesters plus memory side
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_gnt, i_rvalid, i_rdata, if_stall,
               d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for one single-ported sync memory; optional perf counters via ARB_PERF_CNT_EN
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic                Clk,
    input  logic                Rst,
    mem_port_arbiter_if.slave   bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [15:0]         perf_i_stall_cnt,
    output logic [15:0]         perf_d_acc_cnt,
    output logic [7:0]          perf_force_cnt
`endif
);

    typedef enum logic {NORMAL = 1'b0, I_PRIO = 1'b1} state_t;

    localparam logic [4:0] STARVE_LIM = 5'(STARVE_MAX);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       rvalid_q, rvalid_d;
    logic       owner_q, owner_d;   // 1 = fetch owns the outstanding read
    logic       i_gnt, d_gnt;
    logic       starve_hit;

    // the denied cycle that would complete STARVE_MAX consecutive denials
    assign starve_hit = ({1'b0, cnt_q} + 5'd1) == STARVE_LIM;

    // state, starvation counter and response tracking registers
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q  <= NORMAL;
            cnt_q    <= 4'd0;
            rvalid_q <= 1'b0;
            owner_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            owner_q  <= owner_d;
        end
    end

    // next-state and starvation count
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!bus.i_req || i_gnt) begin
            cnt_d = 4'd0;
        end else if (starve_hit) begin
            cnt_d = 4'd0;
        end else if (cnt_q != 4'hF) begin
            cnt_d = cnt_q + 4'd1;
        end
        case (state_q)
            NORMAL: if (bus.i_req && !i_gnt && starve_hit) state_d = I_PRIO;
            I_PRIO: if (i_gnt || !bus.i_req)               state_d = NORMAL;
            default: state_d = NORMAL;
        endcase
    end

    // grant selection from current state
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (state_q == I_PRIO) begin
            if (bus.i_req)      i_gnt = 1'b1;
            else if (bus.d_req) d_gnt = 1'b1;
        end else begin
            if (bus.d_req)      d_gnt = 1'b1;
            else if (bus.i_req) i_gnt = 1'b1;
        end
    end

    // a granted read is answered next cycle; writes leave nothing outstanding
    always_comb begin
        rvalid_d = i_gnt | (d_gnt & ~bus.d_we);
        owner_d  = i_gnt;
    end

    assign bus.i_gnt     = i_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.if_stall  = bus.i_req & ~i_gnt;
    assign bus.mem_en    = i_gnt | d_gnt;
    assign bus.mem_we    = d_gnt & bus.d_we;
    assign bus.mem_addr  = i_gnt ? bus.i_addr : (d_gnt ? bus.d_addr : '0);
    assign bus.mem_wdata = d_gnt ? bus.d_wdata : '0;

    // a response due while reset is asserted is dropped rather than delivered
    assign bus.i_rvalid  = rvalid_q &  owner_q & Rst;
    assign bus.d_rvalid  = rvalid_q & ~owner_q & Rst;
    assign bus.i_rdata   = bus.i_rvalid ? bus.mem_rdata : '0;
    assign bus.d_rdata   = bus.d_rvalid ? bus.mem_rdata : '0;

`ifdef ARB_PERF_CNT_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] dacc_cnt_q;
    logic [7:0]  force_cnt_q;

    // saturating event counters
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            stall_cnt_q <= 16'd0;
            dacc_cnt_q  <= 16'd0;
            force_cnt_q <= 8'd0;
        end else begin
            if (bus.if_stall && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
            if (d_gnt && dacc_cnt_q != 16'hFFFF)         dacc_cnt_q  <= dacc_cnt_q + 16'd1;
            if (state_q == NORMAL && state_d == I_PRIO && force_cnt_q != 8'hFF)
                force_cnt_q <= force_cnt_q + 8'd1;
        end
    end

    assign perf_i_stall_cnt = stall_cnt_q;
    assign perf_d_acc_cnt   = dacc_cnt_q;
    assign perf_force_cnt   = force_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int SM = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

`ifdef ARB_PERF_CNT_EN
    logic [15:0] p_stall;
    logic [15:0] p_dacc;
    logic [7:0]  p_force;
`endif

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(SM)) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_i_stall_cnt (p_stall),
        .perf_d_acc_cnt   (p_dacc),
        .perf_force_cnt   (p_force)
`endif
    );

    typedef struct {
        logic        rst;
        logic        ireq;
        logic [15:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [15:0] daddr;
        logic [15:0] dwdata;
        logic [15:0] mrd;
        logic [70:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [70:0] ex(input logic ig, dg, st, en, we,
                                       input logic [15:0] a, w,
                                       input logic irv, drv,
                                       input logic [15:0] ird, drd);
        return {ig, dg, st, en, we, a, w, irv, drv, ird, drd};
    endfunction

    function automatic logic [70:0] obs();
        return {bus.i_gnt, bus.d_gnt, bus.if_stall, bus.mem_en, bus.mem_we,
                bus.mem_addr, bus.mem_wdata, bus.i_rvalid, bus.d_rvalid,
                bus.i_rdata, bus.d_rdata};
    endfunction

    function automatic vec_t mk(input logic r, ir, input logic [15:0] ia,
                                input logic dr, dw, input logic [15:0] da, dd, md,
                                input logic [70:0] e);
        vec_t v;
        v.rst = r; v.ireq = ir; v.iaddr = ia; v.dreq = dr; v.dwe = dw;
        v.daddr = da; v.dwdata = dd; v.mrd = md; v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [70:0] act, input logic [70:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // applies inputs just after the falling edge, leaving half a cycle to settle
    task automatic drive(input logic r, ir, input logic [15:0] ia,
                         input logic dr, dw, input logic [15:0] da, dd, md);
        @(negedge clk);
        rst = r; bus.i_req = ir; bus.i_addr = ia; bus.d_req = dr; bus.d_we = dw;
        bus.d_addr = da; bus.d_wdata = dd; bus.mem_rdata = md;
        #1;
    endtask

    // behavioural reference state for the random phase
    logic        ip, dp, dwe_m, pv, po;
    logic [15:0] ia_m, da_m, dd_m, mrd_m;
    int          run;

    initial begin
        rst = 1'b0;
        bus.i_req = 1'b1; bus.i_addr = 16'h0020; bus.d_req = 1'b1; bus.d_we = 1'b0;
        bus.d_addr = 16'h0030; bus.d_wdata = 16'h0; bus.mem_rdata = 16'h0;

        // ---------------- directed vector table ----------------
        tbl.push_back(mk(0,1,16'h0020,1,0,16'h0030,16'h0000,16'h0000, ex(0,1,1,1,0,16'h0030,16'h0,0,0,16'h0,16'h0)));
        tbl.push_back(mk(1,1,16'h0020,1,0,16'h0030,16'h0000,16'h0000, ex(0,1,1,1,0,16'h0030,16'h0,0,0,16'h0,16'h0)));
        tbl.push_back(mk(1,1,16'h0020,0,0,16'h0000,16'h0000,16'h1111, ex(1,0,0,1,0,16'h0020,16'h0,0,1,16'h0,16'h1111)));
        tbl.push_back(mk(1,1,16'h0010,0,0,16'h0000,16'h0000,16'h2222, ex(1,0,0,1,0,16'h0010,16'h0,1,0,16'h2222,16'h0)));
        tbl.push_back(mk(1,0,16'h0000,1,1,16'h0100,16'h1234,16'hA5A5, ex(0,1,0,1,1,16'h0100,16'h1234,1,0,16'hA5A5,16'h0)));
        tbl.push_back(mk(1,0,16'h0000,0,0,16'h0000,16'h0000,16'hBEEF, ex(0,0,0,0,0,16'h0,16'h0,0,0,16'h0,16'h0)));
        tbl.push_back(mk(1,1,16'h0300,1,0,16'h0200,16'h0000,16'h5555, ex(0,1,1,1,0,16'h0200,16'h0,0,0,16'h0,16'h0)));
        tbl.push_back(mk(1,1,16'h0300,1,0,16'h0200,16'h0000,16'h5555, ex(0,1,1,1,0,16'h0200,16'h0,0,1,16'h0,16'h5555)));
        tbl.push_back(mk(1,1,16'h0300,1,0,16'h0200,16'h0000,16'h5555, ex(0,1,1,1,0,16'h0200,16'h0,0,1,16'h0,16'h5555)));
        tbl.push_back(mk(1,1,16'h0300,1,0,16'h0200,16'h0000,16'h5555, ex(0,1,1,1,0,16'h0200,16'h0,0,1,16'h0,16'h5555)));
        tbl.push_back(mk(1,1,16'h0300,1,0,16'h0200,16'h0000,16'h5555, ex(1,0,0,1,0,16'h0300,16'h0,0,1,16'h0,16'h5555)));
        tbl.push_back(mk(1,1,16'h0300,1,0,16'h0200,16'h0000,16'h5555, ex(0,1,1,1,0,16'h0200,16'h0,1,0,16'h5555,16'h0)));
        tbl.push_back(mk(1,1,16'h0040,0,0,16'h0000,16'h0000,16'h6666, ex(1,0,0,1,0,16'h0040,16'h0,0,1,16'h0,16'h6666)));
        tbl.push_back(mk(1,0,16'h0000,1,0,16'h0050,16'h0000,16'h7777, ex(0,1,0,1,0,16'h0050,16'h0,1,0,16'h7777,16'h0)));
        tbl.push_back(mk(1,1,16'h0060,0,0,16'h0000,16'h0000,16'h8888, ex(1,0,0,1,0,16'h0060,16'h0,0,1,16'h0,16'h8888)));
        tbl.push_back(mk(1,0,16'h0000,0,0,16'h0000,16'h0000,16'h9999, ex(0,0,0,0,0,16'h0,16'h0,1,0,16'h9999,16'h0)));
        tbl.push_back(mk(1,1,16'h0070,0,0,16'h0000,16'h0000,16'h1357, ex(1,0,0,1,0,16'h0070,16'h0,0,0,16'h0,16'h0)));
        tbl.push_back(mk(0,0,16'h0000,0,0,16'h0000,16'h0000,16'hAAAA, ex(0,0,0,0,0,16'h0,16'h0,0,0,16'h0,16'h0)));
        tbl.push_back(mk(1,0,16'h0000,0,0,16'h0000,16'h0000,16'hBBBB, ex(0,0,0,0,0,16'h0,16'h0,0,0,16'h0,16'h0)));

        // one reset edge with both requests held before the table starts
        @(posedge clk);
        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k].rst, tbl[k].ireq, tbl[k].iaddr, tbl[k].dreq, tbl[k].dwe,
                  tbl[k].daddr, tbl[k].dwdata, tbl[k].mrd);
            check($sformatf("vec%0d", k), obs(), tbl[k].exp);
        end
`ifdef ARB_PERF_CNT_EN
        check("perf_zero_after_reset", {39'd0, p_stall, p_dacc, p_force}, 71'd0);
`endif

        // ---------------- fetch withdrawn while prioritised ----------------
        drive(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0);
        for (int k = 0; k < SM; k++) begin
            drive(1, 1, 16'h0400, 1, 0, 16'h0500, 16'h0, 16'h0);
            check($sformatf("wd_dwin%0d", k), {69'd0, bus.i_gnt, bus.d_gnt}, 71'b01);
        end
        drive(1, 0, 16'h0400, 1, 0, 16'h0500, 16'h0, 16'h0);
        check("wd_withdraw", {69'd0, bus.i_gnt, bus.d_gnt}, 71'b01);
        drive(1, 1, 16'h0400, 1, 0, 16'h0500, 16'h0, 16'h0);
        check("wd_back_normal", {69'd0, bus.i_gnt, bus.d_gnt}, 71'b01);
        drive(1, 0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0);
`ifdef ARB_PERF_CNT_EN
        check("perf_counts", {39'd0, p_stall, p_dacc, p_force},
              {39'd0, 16'd5, 16'd6, 8'd1});
`endif

        // ---------------- randomized against reference model ----------------
        drive(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0);
        ip = 0; dp = 0; pv = 0; po = 0; run = 0;
        ia_m = 0; da_m = 0; dd_m = 0; dwe_m = 0;
        for (int c = 0; c < 400; c++) begin
            logic iw, dg;
            logic [70:0] e;
            if (!ip) begin ip = ($urandom_range(0, 2) != 0); ia_m = 16'($urandom); end
            if (!dp) begin
                dp = 1'($urandom_range(0, 1)); dwe_m = 1'($urandom_range(0, 1));
                da_m = 16'($urandom); dd_m = 16'($urandom);
            end
            mrd_m = 16'($urandom);
            drive(1, ip, ia_m, dp, dwe_m, da_m, dd_m, mrd_m);
            // fetch wins when alone, or once it has been refused SM cycles in a row
            iw = ip && (!dp || run >= SM);
            dg = dp && !iw;
            e = ex(iw, dg, ip && !iw, iw || dg, dg && dwe_m,
                   iw ? ia_m : (dg ? da_m : 16'h0), dg ? dd_m : 16'h0,
                   pv && po, pv && !po,
                   (pv && po) ? mrd_m : 16'h0, (pv && !po) ? mrd_m : 16'h0);
            check($sformatf("rand%0d", c), obs(), e);
            pv = iw || (dg && !dwe_m);
            po = iw;
            if (iw)      begin ip = 0; run = 0; end
            else if (ip) run++;
            else         run = 0;
            if (dg) dp = 0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
